// File: rtl/stack_op_sequencer_pkg.sv
// Shared command, stack-op, push-source and FSM encodings for the stack op sequencer.
package stack_op_sequencer_pkg;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned OP_W   = 3;
  localparam int unsigned REG_W  = 2;

  typedef enum logic [2:0] {
    OP_NOP      = 3'd0,
    OP_PUSH_IMM = 3'd1,
    OP_POP      = 3'd2,
    OP_POP2     = 3'd3,
    OP_LOAD     = 3'd4,
    OP_STORE    = 3'd5,
    OP_REG_WR   = 3'd6,
    OP_REG_RD   = 3'd7
  } cmd_op_e;

  typedef enum logic [1:0] {
    ES_NOP  = 2'b00,
    ES_PUSH = 2'b01,
    ES_POP  = 2'b10
  } es_op_e;

  typedef enum logic [1:0] {
    SRC_ZERO = 2'd0,
    SRC_IMM  = 2'd1,
    SRC_MEM  = 2'd2,
    SRC_REG  = 2'd3
  } push_src_e;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    MEM_WAIT = 3'd1,
    WRITE    = 3'd2,
    STACK    = 3'd3,
    SETTLE   = 3'd4
  } state_e;

  // Commands whose stack action is a push.
  function automatic logic op_pushes(cmd_op_e op);
    return (op == OP_PUSH_IMM) || (op == OP_LOAD) || (op == OP_REG_RD);
  endfunction

  // Entries that must already be on the stack for the command to run.
  function automatic logic [1:0] op_needs(cmd_op_e op);
    case (op)
      OP_POP, OP_LOAD, OP_REG_WR: return 2'd1;
      OP_POP2, OP_STORE:          return 2'd2;
      default:                    return 2'd0;
    endcase
  endfunction

  // Entries removed by the stack action.
  function automatic logic [1:0] op_pops(cmd_op_e op);
    case (op)
      OP_POP, OP_REG_WR:  return 2'd1;
      OP_POP2, OP_STORE:  return 2'd2;
      default:            return 2'd0;
    endcase
  endfunction

  // Datapath push source for pushing commands.
  function automatic push_src_e op_src(cmd_op_e op);
    case (op)
      OP_PUSH_IMM: return SRC_IMM;
      OP_LOAD:     return SRC_MEM;
      OP_REG_RD:   return SRC_REG;
      default:     return SRC_ZERO;
    endcase
  endfunction

endpackage

// File: rtl/stack_op_sequencer_if.sv
// Command handshake plus datapath control bus of the stack op sequencer.
interface stack_op_sequencer_if #(
  parameter int unsigned DEPTH = 16
);
  import stack_op_sequencer_pkg::*;

  logic                        cmd_valid;
  logic                        cmd_ready;
  logic [OP_W-1:0]             cmd_op;
  logic [DATA_W-1:0]           cmd_imm;
  logic [REG_W-1:0]            cmd_reg;
  logic [DATA_W-1:0]           push_data;
  logic [1:0]                  push_src;
  logic [1:0]                  es_op;
  logic                        es_act;
  logic                        pop_num;
  logic                        wea;
  logic                        reg_write;
  logic [REG_W-1:0]            reg_address;
  logic                        done;
  logic                        err;
  logic [$clog2(DEPTH+1)-1:0]  depth;

  // Requester / datapath side.
  modport master (
    output cmd_valid, cmd_op, cmd_imm, cmd_reg,
    input  cmd_ready, push_data, push_src, es_op, es_act, pop_num,
           wea, reg_write, reg_address, done, err, depth
  );

  // Sequencer side.
  modport slave (
    input  cmd_valid, cmd_op, cmd_imm, cmd_reg,
    output cmd_ready, push_data, push_src, es_op, es_act, pop_num,
           wea, reg_write, reg_address, done, err, depth
  );

endinterface

// File: rtl/stack_depth_tracker.sv
// Tracks expression-stack occupancy and flags over/underflow for an incoming command.
module stack_depth_tracker
  import stack_op_sequencer_pkg::*;
#(
  parameter int unsigned DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  cmd_op_e                    check_op,
  output logic                       check_err_c,
  input  logic                       commit,
  input  cmd_op_e                    commit_op,
  output logic [$clog2(DEPTH+1)-1:0] depth
);

  localparam int unsigned DW = $clog2(DEPTH + 1);
  localparam logic [DW-1:0] FULL = DW'(DEPTH);

  // Overflow if a push finds the stack full; underflow if operands are missing.
  always_comb begin
    check_err_c = 1'b0;
    if (op_pushes(check_op) && (depth == FULL)) begin
      check_err_c = 1'b1;
    end
    if (32'(op_needs(check_op)) > 32'(depth)) begin
      check_err_c = 1'b1;
    end
  end

  // Occupancy moves when the STACK state is left.
  always_ff @(posedge clk) begin
    if (!reset) begin
      depth <= '0;
    end else if (commit) begin
      if (op_pushes(commit_op)) begin
        depth <= depth + DW'(1);
      end else begin
        depth <= depth - DW'(op_pops(commit_op));
      end
    end
  end

endmodule

// File: rtl/stack_op_sequencer.sv
// Sequences stack-machine commands into memory, register-file and stack strobes.
module stack_op_sequencer
  import stack_op_sequencer_pkg::*;
#(
  parameter int unsigned DEPTH = 16
) (
  input  logic                clk,
  input  logic                reset,
  stack_op_sequencer_if.slave bus
);

  state_e  state, state_n;
  cmd_op_e op_q, op_n;
  logic    err_q, err_n;
  logic    accept_c;
  logic    check_err_c;

  assign accept_c = (state == IDLE) && bus.cmd_valid;

  stack_depth_tracker #(.DEPTH(DEPTH)) u_tracker (
    .clk         (clk),
    .reset       (reset),
    .check_op    (cmd_op_e'(bus.cmd_op)),
    .check_err_c (check_err_c),
    .commit      (state == STACK),
    .commit_op   (op_q),
    .depth       (bus.depth)
  );

  // Next state and next latched command.
  always_comb begin
    state_n = state;
    op_n    = op_q;
    err_n   = err_q;
    case (state)
      IDLE: begin
        if (accept_c) begin
          op_n  = cmd_op_e'(bus.cmd_op);
          err_n = check_err_c;
          if (check_err_c || (op_n == OP_NOP)) begin
            state_n = SETTLE;
          end else if (op_n == OP_LOAD) begin
            state_n = MEM_WAIT;
          end else if ((op_n == OP_STORE) || (op_n == OP_REG_WR)) begin
            state_n = WRITE;
          end else begin
            state_n = STACK;
          end
        end
      end
      MEM_WAIT, WRITE: state_n = STACK;
      STACK:           state_n = SETTLE;
      SETTLE:          state_n = IDLE;
      default:         state_n = IDLE;
    endcase
  end

  // State, latched command and outputs decoded from the state being entered.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state           <= IDLE;
      op_q            <= OP_NOP;
      err_q           <= 1'b0;
      bus.cmd_ready   <= 1'b1;
      bus.push_data   <= '0;
      bus.reg_address <= '0;
      bus.push_src    <= SRC_ZERO;
      bus.es_op       <= ES_NOP;
      bus.es_act      <= 1'b0;
      bus.pop_num     <= 1'b0;
      bus.wea         <= 1'b0;
      bus.reg_write   <= 1'b0;
      bus.done        <= 1'b0;
      bus.err         <= 1'b0;
    end else begin
      state <= state_n;
      op_q  <= op_n;
      err_q <= err_n;
      if (accept_c) begin
        bus.push_data   <= bus.cmd_imm;
        bus.reg_address <= bus.cmd_reg;
      end
      bus.cmd_ready <= (state_n == IDLE);
      bus.wea       <= (state_n == WRITE) && (op_n == OP_STORE);
      bus.reg_write <= (state_n == WRITE) && (op_n == OP_REG_WR);
      bus.es_act    <= (state_n == STACK);
      bus.es_op     <= (state_n == STACK) ? (op_pushes(op_n) ? ES_PUSH : ES_POP) : ES_NOP;
      bus.push_src  <= (state_n == STACK) ? op_src(op_n) : SRC_ZERO;
      bus.pop_num   <= (state_n == STACK) && (op_pops(op_n) == 2'd2);
      bus.done      <= (state_n == SETTLE);
      bus.err       <= (state_n == SETTLE) && err_n;
    end
  end

endmodule

// File: tb/tb_stack_op_sequencer.sv
// Randomized self-checking bench with a per-command expected-cycle scoreboard.
module tb_stack_op_sequencer;
  import stack_op_sequencer_pkg::*;

  localparam int unsigned DEPTH = 16;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  stack_op_sequencer_if #(.DEPTH(DEPTH)) bus ();

  stack_op_sequencer #(.DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Expected outputs for one clock cycle.
  typedef struct {
    int rdy; int act; int op; int src; int pn;
    int wea; int rw; int done; int err; int delta;
  } rec_t;

  rec_t        q[$];
  int          m_depth = 0;
  logic        m_rst = 1'b1;
  logic        m_latched = 1'b0;
  logic [15:0] m_imm = '0;
  logic [1:0]  m_reg = '0;
  int          n_checks = 0;
  int          n_fail = 0;

  function automatic rec_t r_blank();
    rec_t r;
    r = '{rdy:0, act:0, op:0, src:0, pn:0, wea:0, rw:0, done:0, err:0, delta:0};
    return r;
  endfunction

  function automatic rec_t r_idle();
    rec_t r = r_blank();
    r.rdy = 1;
    return r;
  endfunction

  function automatic rec_t r_push(int src);
    rec_t r = r_blank();
    r.act = 1; r.op = 1; r.src = src; r.delta = 1;
    return r;
  endfunction

  function automatic rec_t r_pop(int n);
    rec_t r = r_blank();
    r.act = 1; r.op = 2; r.pn = (n == 2) ? 1 : 0; r.delta = -n;
    return r;
  endfunction

  function automatic rec_t r_done(int e);
    rec_t r = r_blank();
    r.done = 1; r.err = e;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  // Compare this cycle's DUT outputs against the scoreboard head.
  task automatic observe(output logic was_idle);
    rec_t e;
    was_idle = (q.size() == 0);
    e = was_idle ? r_idle() : q.pop_front();
    if (!m_rst) chk("cmd_ready", 32'(bus.cmd_ready), 32'(e.rdy));
    chk("es_act",    32'(bus.es_act),    32'(e.act));
    chk("es_op",     32'(bus.es_op),     32'(e.op));
    chk("push_src",  32'(bus.push_src),  32'(e.src));
    chk("pop_num",   32'(bus.pop_num),   32'(e.pn));
    chk("wea",       32'(bus.wea),       32'(e.wea));
    chk("reg_write", 32'(bus.reg_write), 32'(e.rw));
    chk("done",      32'(bus.done),      32'(e.done));
    chk("err",       32'(bus.err),       32'(e.err));
    chk("depth",     32'(bus.depth),     32'(m_depth));
    if (m_latched) begin
      chk("push_data",   32'(bus.push_data),   32'(m_imm));
      chk("reg_address", 32'(bus.reg_address), 32'(m_reg));
    end
    m_depth += e.delta;
  endtask

  // Build the expected cycle sequence of an accepted command.
  task automatic accept(input logic [2:0] op, input logic [15:0] imm, input logic [1:0] rg);
    int need;
    bit push;
    bit e;
    need = (op == 3'd2 || op == 3'd4 || op == 3'd6) ? 1 : (op == 3'd3 || op == 3'd5) ? 2 : 0;
    push = (op == 3'd1 || op == 3'd4 || op == 3'd7);
    e = (push && m_depth == int'(DEPTH)) || (need > m_depth);
    m_imm = imm;
    m_reg = rg;
    m_latched = 1'b1;
    if (!e) begin
      case (op)
        3'd1: q.push_back(r_push(1));
        3'd2: q.push_back(r_pop(1));
        3'd3: q.push_back(r_pop(2));
        3'd4: begin q.push_back(r_blank()); q.push_back(r_push(2)); end
        3'd5: begin
          rec_t w = r_blank();
          w.wea = 1;
          q.push_back(w);
          q.push_back(r_pop(2));
        end
        3'd6: begin
          rec_t w = r_blank();
          w.rw = 1;
          q.push_back(w);
          q.push_back(r_pop(1));
        end
        3'd7: q.push_back(r_push(3));
        default: ;
      endcase
    end
    q.push_back(r_done(e ? 1 : 0));
  endtask

  // One clock: check outputs at negedge, then drive inputs for the next edge.
  task automatic cycle(input logic r, input logic v, input logic [2:0] op,
                       input logic [15:0] imm, input logic [1:0] rg);
    logic idle;
    @(negedge clk);
    observe(idle);
    if (m_rst) v = 1'b0;
    reset         = r;
    bus.cmd_valid = v;
    bus.cmd_op    = op;
    bus.cmd_imm   = imm;
    bus.cmd_reg   = rg;
    if (!r) begin
      q.delete();
      m_depth   = 0;
      m_latched = 1'b0;
      m_rst     = 1'b1;
    end else begin
      m_rst = 1'b0;
      if (idle && v) accept(op, imm, rg);
    end
  endtask

  task automatic idle_cycle();
    cycle(1'b1, 1'b0, 3'd0, 16'h0, 2'd0);
  endtask

  initial begin
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = '0;
    bus.cmd_imm   = '0;
    bus.cmd_reg   = '0;

    // Reset, then PUSH_IMM 0x1234.
    cycle(1'b0, 1'b0, 3'd0, 16'h0, 2'd0);
    cycle(1'b0, 1'b0, 3'd0, 16'h0, 2'd0);
    idle_cycle();
    chk("lit_rst_done", 32'(bus.done), 32'd0);
    cycle(1'b1, 1'b1, 3'd1, 16'h1234, 2'd0);
    chk("lit_ready", 32'(bus.cmd_ready), 32'd1);
    chk("lit_depth0", 32'(bus.depth), 32'd0);
    idle_cycle();
    chk("lit_push_act", 32'(bus.es_act), 32'd1);
    chk("lit_push_op", 32'(bus.es_op), 32'd1);
    chk("lit_push_src", 32'(bus.push_src), 32'd1);
    chk("lit_push_data", 32'(bus.push_data), 32'h1234);
    idle_cycle();
    chk("lit_push_done", 32'(bus.done), 32'd1);
    chk("lit_push_depth", 32'(bus.depth), 32'd1);

    // Second push, then STORE from depth 2.
    cycle(1'b1, 1'b1, 3'd1, 16'hBEEF, 2'd0);
    idle_cycle();
    idle_cycle();
    cycle(1'b1, 1'b1, 3'd5, 16'h0, 2'd0);
    idle_cycle();
    chk("lit_store_wea", 32'(bus.wea), 32'd1);
    idle_cycle();
    chk("lit_store_op", 32'(bus.es_op), 32'd2);
    chk("lit_store_pn", 32'(bus.pop_num), 32'd1);
    idle_cycle();
    chk("lit_store_done", 32'(bus.done), 32'd1);
    chk("lit_store_depth", 32'(bus.depth), 32'd0);

    // LOAD from depth 1.
    cycle(1'b1, 1'b1, 3'd1, 16'h0055, 2'd0);
    idle_cycle();
    idle_cycle();
    cycle(1'b1, 1'b1, 3'd4, 16'h0, 2'd0);
    idle_cycle();
    chk("lit_load_wait_act", 32'(bus.es_act), 32'd0);
    idle_cycle();
    chk("lit_load_src", 32'(bus.push_src), 32'd2);
    chk("lit_load_op", 32'(bus.es_op), 32'd1);
    idle_cycle();
    chk("lit_load_done", 32'(bus.done), 32'd1);
    chk("lit_load_depth", 32'(bus.depth), 32'd2);

    // POP on an empty stack.
    cycle(1'b0, 1'b0, 3'd0, 16'h0, 2'd0);
    idle_cycle();
    cycle(1'b1, 1'b1, 3'd2, 16'h0, 2'd0);
    idle_cycle();
    chk("lit_under_done", 32'(bus.done), 32'd1);
    chk("lit_under_err", 32'(bus.err), 32'd1);
    chk("lit_under_act", 32'(bus.es_act), 32'd0);
    chk("lit_under_depth", 32'(bus.depth), 32'd0);
    idle_cycle();

    // DEPTH+1 pushes; the last one overflows.
    for (int i = 0; i <= int'(DEPTH); i++) begin
      cycle(1'b1, 1'b1, 3'd1, 16'(i), 2'd0);
      if (i < int'(DEPTH)) begin
        idle_cycle();
        idle_cycle();
      end
    end
    idle_cycle();
    chk("lit_over_done", 32'(bus.done), 32'd1);
    chk("lit_over_err", 32'(bus.err), 32'd1);
    chk("lit_over_depth", 32'(bus.depth), 32'd16);
    idle_cycle();

    // Reset during the WRITE of REG_WR.
    cycle(1'b1, 1'b1, 3'd6, 16'h0, 2'd2);
    cycle(1'b0, 1'b0, 3'd0, 16'h0, 2'd0);
    chk("lit_regwr_write", 32'(bus.reg_write), 32'd1);
    idle_cycle();
    chk("lit_abort_act", 32'(bus.es_act), 32'd0);
    chk("lit_abort_done", 32'(bus.done), 32'd0);
    chk("lit_abort_depth", 32'(bus.depth), 32'd0);
    idle_cycle();
    chk("lit_abort_ready", 32'(bus.cmd_ready), 32'd1);

    // Random traffic with occasional resets and held cmd_valid.
    for (int i = 0; i < 3000; i++) begin
      cycle(($urandom_range(0, 99) != 0) ? 1'b1 : 1'b0,
            ($urandom_range(0, 9) < 6) ? 1'b1 : 1'b0,
            3'($urandom_range(0, 7)),
            16'($urandom),
            2'($urandom_range(0, 3)));
    end
    idle_cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/stack_op_sequencer.md
STACK_OP_SEQUENCER -- requirements
Module: stack_op_sequencer

Interface
REQ-001 SHALL have parameter DEPTH, default 16, meaning the expression-stack capacity in entries.
REQ-002 SHALL have port clk  input  1  single clock; all state changes on the rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-low reset, sampled on the clk rising edge.
REQ-004 SHALL have port cmd_valid  input  1  requester presents a command.
REQ-005 SHALL have port cmd_ready  output  1  sequencer can accept a command; high only in IDLE.
REQ-006 SHALL have port cmd_op  input  3  command: 0 NOP, 1 PUSH_IMM, 2 POP, 3 POP2, 4 LOAD, 5 STORE, 6 REG_WR, 7 REG_RD.
REQ-007 SHALL have port cmd_imm  input  16  immediate for PUSH_IMM.
REQ-008 SHALL have port cmd_reg  input  2  register-file address for REG_WR/REG_RD.
REQ-009 SHALL have port push_data  output  16  latched cmd_imm, routed to the datapath push input.
REQ-010 SHALL have port push_src  output  2  push-source select: 0 zero, 1 immediate, 2 memory, 3 register file.
REQ-011 SHALL have port es_op  output  2  expression-stack operation: 00 NOP, 01 PUSH, 10 POP.
REQ-012 SHALL have port es_act  output  1  expression-stack action strobe.
REQ-013 SHALL have port pop_num  output  1  0 = pop one entry, 1 = pop two entries.
REQ-014 SHALL have port wea  output  1  block-memory write strobe; address = A, data = B.
REQ-015 SHALL have port reg_write  output  1  register-file write strobe; data = A.
REQ-016 SHALL have port reg_address  output  2  latched cmd_reg.
REQ-017 SHALL have port done  output  1  one-cycle pulse marking command completion.
REQ-018 SHALL have port err  output  1  qualifies done; overflow or underflow; command not executed.
REQ-019 SHALL have port depth  output  $clog2(DEPTH+1)  tracked stack occupancy.

Function
REQ-020 A command SHALL be accepted on the rising edge where cmd_valid && cmd_ready; cmd_op, cmd_imm and cmd_reg are registered at that edge.
REQ-021 The FSM SHALL use states IDLE, MEM_WAIT, WRITE, STACK, SETTLE; all outputs SHALL be Moore outputs decoded from state and the latched command.
REQ-022 State paths SHALL be: PUSH_IMM/POP/POP2/REG_RD: STACK->SETTLE; LOAD: MEM_WAIT->STACK->SETTLE; STORE and REG_WR: WRITE->STACK->SETTLE; NOP or error: SETTLE only; SETTLE->IDLE.
REQ-023 MEM_WAIT SHALL drive no strobes and exists only to cover the one-cycle block-memory read latency.
REQ-024 WRITE SHALL assert wea=1 for STORE and reg_write=1 for REG_WR, for exactly one cycle.
REQ-025 STACK SHALL assert es_act=1 for exactly one cycle, with: PUSH_IMM es_op=01, push_src=1; LOAD es_op=01, push_src=2; REG_RD es_op=01, push_src=3; POP and REG_WR es_op=10, pop_num=0; POP2 and STORE es_op=10, pop_num=1.
REQ-026 SETTLE SHALL assert done=1 for one cycle, covering the A/B output-register delay; results are valid on A/B when done is high.
REQ-027 Outside STACK, es_act=0, es_op=00, push_src=0 and pop_num=0.
REQ-028 depth SHALL update at the STACK-exit edge: +1 for PUSH_IMM/LOAD/REG_RD, -1 for POP/REG_WR, -2 for POP2/STORE.
REQ-029 An error SHALL be flagged at acceptance if a push is requested with depth==DEPTH, or a command needs more entries than depth holds (POP/LOAD/REG_WR need 1; POP2/STORE need 2). Such a command SHALL go directly to SETTLE with done=1, err=1, no strobes, and depth unchanged.
REQ-030 err SHALL be 0 whenever done is 0.
REQ-031 cmd_valid SHALL be ignored outside IDLE; a requester holding cmd_valid high through done SHALL be accepted on the cycle after SETTLE.
REQ-032 Minimum accept-to-accept spacing SHALL be: 3 cycles for STACK-only commands, 4 for LOAD/STORE/REG_WR, 2 for NOP/error.

Reset
REQ-033 While reset==0 at an edge, the FSM SHALL go to IDLE, depth SHALL be 0, and every strobe, done and err SHALL be 0; cmd_ready SHALL be 1 from the first cycle after reset is released.
REQ-034 A reset asserted mid-command SHALL abort the command with no further strobes and no done pulse.

Structure
REQ-035 A shared package SHALL hold the cmd_op codes, the es_op codes, the push_src codes and the FSM state enum.
REQ-036 The depth/error check SHALL be one natural sub-module, stack_depth_tracker; everything else SHALL be a single FSM.

Verification
REQ-037 Reset then PUSH_IMM 0x1234 -> es_act=1, es_op=01, push_src=1, push_data=0x1234 in STACK; done one cycle later; depth=1.
REQ-038 From depth 2, STORE -> wea=1 in WRITE, then es_op=10, pop_num=1 in STACK, then done; depth=0.
REQ-039 From depth 1, LOAD -> one cycle with no strobes, then PUSH with push_src=2, then done; depth=2.
REQ-040 From depth 0, POP -> done=1 and err=1 on the cycle after acceptance; no strobes; depth=0.
REQ-041 Push DEPTH+1 times -> the last push gets err=1 and depth stays at 16.
REQ-042 Reset pulled low during WRITE of REG_WR -> no STACK strobe, no done; depth=0; cmd_ready=1 after release.
